// File: rtl/romdisk_ctrl.sv
// ROM-disk controller: maps PPA ports B/C plus a latched page onto a DDR3 byte
// address, caches 64-bit lines for CPU reads and forwards ioctl download writes.
module romdisk_ctrl #(
    parameter int          PAGE_W  = 4,
    parameter int          CL_BITS = 2,
    parameter logic [28:0] BASE    = 29'h0,
    localparam int         AW      = PAGE_W + 15
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic [7:0]    port_b,
    input  logic [7:0]    port_c,
    input  logic          rd,
    output logic [7:0]    dout,
    output logic          ready,
    input  logic          dl_en,
    input  logic [AW-1:0] dl_addr,
    input  logic [7:0]    dl_data,
    input  logic          dl_wr,
    output logic          dl_wait,
    input  logic          ddr_busy,
    output logic [28:0]   ddr_addr,
    output logic [7:0]    ddr_burstcnt,
    output logic          ddr_rd,
    output logic          ddr_we,
    output logic [63:0]   ddr_din,
    output logic [7:0]    ddr_be,
    input  logic [63:0]   ddr_dout,
    input  logic          ddr_dout_ready
);
    localparam int LINES = 1 << CL_BITS;
    localparam int TW    = AW - CL_BITS - 3;

    typedef enum logic [1:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ} state_t;

    state_t            state_q, state_d;
    logic              armed_q, armed_d;
    logic              strobe_q, strobe_d;
    logic              rd_q, rd_d;
    logic              dl_en_q, dl_en_d;
    logic [PAGE_W-1:0] page_q, page_d;
    logic [AW-1:0]     rd_addr_q, rd_addr_d;
    logic [AW-1:0]     wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic [7:0]        dout_q, dout_d;
    logic              ready_q, ready_d;
    logic              dl_wait_q, dl_wait_d;
    logic [LINES-1:0]  valid_q, valid_d;
    logic [TW-1:0]     tag_q [LINES];
    logic [63:0]       line_q [LINES];

    logic [AW-1:0]      byte_addr;
    logic [CL_BITS-1:0] lk_idx, rd_idx;
    logic [TW-1:0]      lk_tag;
    logic [63:0]        lk_line;
    logic               lk_hit, rd_edge, fill_en;
    logic [AW-1:0]      req_addr;

    always_comb begin
        byte_addr = {page_q, port_c[6:0], port_b};
        lk_idx    = byte_addr[CL_BITS+2:3];
        lk_tag    = byte_addr[AW-1:CL_BITS+3];
        lk_line   = line_q[lk_idx];
        lk_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        rd_idx    = rd_addr_q[CL_BITS+2:3];
        // armed_q keeps levels already high at reset release from counting as edges
        rd_edge   = armed_q && rd && !rd_q && !dl_en;
    end

    always_comb begin
        state_d   = state_q;
        armed_d   = 1'b1;
        strobe_d  = port_c[7];
        rd_d      = rd;
        dl_en_d   = dl_en;
        page_d    = page_q;
        rd_addr_d = rd_addr_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        dout_d    = dout_q;
        ready_d   = ready_q;
        dl_wait_d = dl_wait_q;
        valid_d   = valid_q;
        fill_en   = 1'b0;
        ddr_rd    = 1'b0;
        ddr_we    = 1'b0;

        if (armed_q && port_c[7] && !strobe_q)
            page_d = port_b[PAGE_W-1:0];

        // A write is captured in any state; the FSM issues it once back in IDLE
        if (dl_wr && !dl_wait_q) begin
            wr_addr_d = dl_addr;
            wr_data_d = dl_data;
            dl_wait_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (dl_wr || dl_wait_q) begin
                    state_d = WR_REQ;
                end else if (rd_edge) begin
                    if (lk_hit) begin
                        dout_d = lk_line[{byte_addr[2:0], 3'b000} +: 8];
                    end else begin
                        ready_d   = 1'b0;
                        rd_addr_d = byte_addr;
                        state_d   = RD_REQ;
                    end
                end
            end
            RD_REQ: begin
                ddr_rd = 1'b1;
                if (!ddr_busy)
                    state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (ddr_dout_ready) begin
                    fill_en = 1'b1;
                    // a line fetched while a download runs may go stale, so leave it invalid
                    if (!dl_en)
                        valid_d[rd_idx] = 1'b1;
                    dout_d  = ddr_dout[{rd_addr_q[2:0], 3'b000} +: 8];
                    ready_d = 1'b1;
                    state_d = IDLE;
                end
            end
            WR_REQ: begin
                ddr_we = 1'b1;
                if (!ddr_busy) begin
                    dl_wait_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (armed_q && dl_en && !dl_en_q)
            valid_d = '0;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            armed_q   <= 1'b0;
            strobe_q  <= 1'b0;
            rd_q      <= 1'b0;
            dl_en_q   <= 1'b0;
            page_q    <= '0;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            dout_q    <= 8'hFF;
            ready_q   <= 1'b1;
            dl_wait_q <= 1'b0;
            valid_q   <= '0;
        end else begin
            state_q   <= state_d;
            armed_q   <= armed_d;
            strobe_q  <= strobe_d;
            rd_q      <= rd_d;
            dl_en_q   <= dl_en_d;
            page_q    <= page_d;
            rd_addr_q <= rd_addr_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            dout_q    <= dout_d;
            ready_q   <= ready_d;
            dl_wait_q <= dl_wait_d;
            valid_q   <= valid_d;
        end
    end

    // Line data and tags are qualified by valid_q, so they need no reset
    always_ff @(posedge clk_sys) begin
        if (fill_en) begin
            line_q[rd_idx] <= ddr_dout;
            tag_q[rd_idx]  <= rd_addr_q[AW-1:CL_BITS+3];
        end
    end

    always_comb begin
        req_addr     = (state_q == WR_REQ) ? wr_addr_q : rd_addr_q;
        ddr_addr     = BASE + 29'(req_addr[AW-1:3]);
        ddr_burstcnt = 8'd1;
        ddr_din      = {8{wr_data_q}};
        ddr_be       = 8'b1 << wr_addr_q[2:0];
        dout         = dout_q;
        ready        = ready_q;
        dl_wait      = dl_wait_q;
    end

endmodule

// File: tb/tb_romdisk_ctrl.sv
// Directed bench for romdisk_ctrl: page latch, cache hit/miss, download writes,
// write-during-miss ordering, index conflicts and reset during a fill.
module tb_romdisk_ctrl;
  localparam logic [28:0] BASE = 29'h0100000;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  port_b = 8'h00;
  logic [7:0]  port_c = 8'h00;
  logic        rd = 1'b0;
  logic [7:0]  dout;
  logic        ready;
  logic        dl_en = 1'b0;
  logic [18:0] dl_addr = '0;
  logic [7:0]  dl_data = 8'h00;
  logic        dl_wr = 1'b0;
  logic        dl_wait;
  logic        ddr_busy = 1'b0;
  logic [28:0] ddr_addr;
  logic [7:0]  ddr_burstcnt;
  logic        ddr_rd;
  logic        ddr_we;
  logic [63:0] ddr_din;
  logic [7:0]  ddr_be;
  logic [63:0] ddr_dout = '0;
  logic        ddr_dout_ready = 1'b0;

  int total = 0;
  int bad = 0;

  romdisk_ctrl #(.PAGE_W(4), .CL_BITS(2), .BASE(BASE)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .port_b(port_b), .port_c(port_c),
    .rd(rd), .dout(dout), .ready(ready), .dl_en(dl_en), .dl_addr(dl_addr),
    .dl_data(dl_data), .dl_wr(dl_wr), .dl_wait(dl_wait), .ddr_busy(ddr_busy),
    .ddr_addr(ddr_addr), .ddr_burstcnt(ddr_burstcnt), .ddr_rd(ddr_rd),
    .ddr_we(ddr_we), .ddr_din(ddr_din), .ddr_be(ddr_be), .ddr_dout(ddr_dout),
    .ddr_dout_ready(ddr_dout_ready)
  );

  // clock
  always #5 clk_sys = ~clk_sys;

  // ---------------- driver tasks ----------------
  task automatic set_page(input logic [7:0] p);
    port_b = p;
    port_c[7] = 1'b1;
    @(negedge clk_sys);
    port_c[7] = 1'b0;
    @(negedge clk_sys);
  endtask

  task automatic set_addr(input logic [14:0] a);
    port_c = {1'b0, a[14:8]};
    port_b = a[7:0];
  endtask

  // One-cycle rd pulse; returns at the negedge after the lookup was registered.
  task automatic pulse_rd();
    @(negedge clk_sys);
    rd = 1'b1;
    @(negedge clk_sys);
    rd = 1'b0;
  endtask

  // Waits (bounded) for a read request, lets it be accepted, then returns data
  // lat cycles after acceptance. Returns at the negedge after the fill.
  task automatic ddr_reply(input logic [63:0] data, input int lat);
    int n;
    n = 0;
    while (ddr_rd !== 1'b1 && n < 20) begin
      @(negedge clk_sys);
      n++;
    end
    total++;
    if (ddr_rd !== 1'b1) begin
      bad++;
      $display("FAIL ddr_reply_timeout: ddr_rd=%b after %0d cycles, want 1", ddr_rd, n);
    end else begin
      @(negedge clk_sys);
      repeat (lat - 1) @(negedge clk_sys);
      ddr_dout = data;
      ddr_dout_ready = 1'b1;
      @(negedge clk_sys);
      ddr_dout_ready = 1'b0;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    port_c = 8'h80;
    port_b = 8'h03;
    repeat (3) @(negedge clk_sys);
    total++; if (dout !== 8'hFF) begin bad++; $display("FAIL reset_dout: got %h want ff", dout); end
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", ready); end
    total++; if (dl_wait !== 1'b0) begin bad++; $display("FAIL reset_dl_wait: got %b want 0", dl_wait); end
    total++; if (ddr_rd !== 1'b0 || ddr_we !== 1'b0) begin bad++; $display("FAIL reset_ddr_req: rd=%b we=%b want 0 0", ddr_rd, ddr_we); end
    total++; if (ddr_burstcnt !== 8'd1) begin bad++; $display("FAIL burstcnt: got %h want 01", ddr_burstcnt); end
    // strobe already high at release must not latch page 3
    reset_n = 1'b1;
    repeat (2) @(negedge clk_sys);
    port_c = 8'h00;
    port_b = 8'h00;
    @(negedge clk_sys);
    pulse_rd();
    total++; if (ddr_rd !== 1'b1 || ddr_addr !== BASE) begin bad++; $display("FAIL strobe_at_release: rd=%b addr=%h want 1 %h", ddr_rd, ddr_addr, BASE); end
    ddr_reply(64'h00000000000000AB, 2);
    total++; if (dout !== 8'hAB) begin bad++; $display("FAIL reset_first_read: got %h want ab", dout); end
  endtask

  task automatic test_page();
    set_page(8'h05);
    set_addr(15'h0000);
    pulse_rd();
    total++; if (ddr_addr !== BASE + 29'h5000) begin bad++; $display("FAIL page_addr: got %h want %h", ddr_addr, BASE + 29'h5000); end
    ddr_reply(64'h123456789ABCDE5A, 3);
    total++; if (dout !== 8'h5A) begin bad++; $display("FAIL page_read: got %h want 5a", dout); end
    set_page(8'h00);
  endtask

  task automatic test_cold_read();
    set_addr(15'h0123);
    pulse_rd();
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL cold_ready_low: got %b want 0", ready); end
    total++; if (ddr_rd !== 1'b1 || ddr_we !== 1'b0) begin bad++; $display("FAIL cold_req: rd=%b we=%b want 1 0", ddr_rd, ddr_we); end
    total++; if (ddr_addr !== BASE + 29'h24) begin bad++; $display("FAIL cold_addr: got %h want %h", ddr_addr, BASE + 29'h24); end
    @(negedge clk_sys);
    total++; if (ddr_rd !== 1'b0) begin bad++; $display("FAIL cold_single_req: ddr_rd=%b want 0", ddr_rd); end
    repeat (4) @(negedge clk_sys);
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL cold_ready_wait: got %b want 0", ready); end
    ddr_dout = 64'h8877665544332211;
    ddr_dout_ready = 1'b1;
    @(negedge clk_sys);
    ddr_dout_ready = 1'b0;
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL cold_ready_back: got %b want 1", ready); end
    total++; if (dout !== 8'h44) begin bad++; $display("FAIL cold_dout: got %h want 44", dout); end
  endtask

  task automatic test_hit();
    set_addr(15'h0124);
    pulse_rd();
    total++; if (ready !== 1'b1 || ddr_rd !== 1'b0) begin bad++; $display("FAIL hit_no_req: ready=%b rd=%b want 1 0", ready, ddr_rd); end
    total++; if (dout !== 8'h55) begin bad++; $display("FAIL hit_dout: got %h want 55", dout); end
  endtask

  task automatic test_download();
    dl_en = 1'b1;
    @(negedge clk_sys);
    set_addr(15'h0120);
    pulse_rd();
    total++; if (ready !== 1'b1 || ddr_rd !== 1'b0 || dout !== 8'h55) begin bad++; $display("FAIL dl_masks_rd: ready=%b rd=%b dout=%h want 1 0 55", ready, ddr_rd, dout); end
    dl_addr = 19'h00121;
    dl_data = 8'hA5;
    dl_wr = 1'b1;
    ddr_busy = 1'b1;
    @(negedge clk_sys);
    dl_wr = 1'b0;
    total++; if (ddr_be !== 8'h02 || ddr_din !== {8{8'hA5}}) begin bad++; $display("FAIL dl_be_din: be=%h din=%h want 02 a5x8", ddr_be, ddr_din); end
    total++; if (ddr_addr !== BASE + 29'h24 || ddr_rd !== 1'b0) begin bad++; $display("FAIL dl_addr: addr=%h rd=%b want %h 0", ddr_addr, ddr_rd, BASE + 29'h24); end
    for (int i = 0; i < 4; i++) begin
      if (i == 3) ddr_busy = 1'b0;
      total++; if (dl_wait !== 1'b1 || ddr_we !== 1'b1) begin bad++; $display("FAIL dl_wait_high_%0d: wait=%b we=%b want 1 1", i, dl_wait, ddr_we); end
      @(negedge clk_sys);
    end
    total++; if (dl_wait !== 1'b0 || ddr_we !== 1'b0) begin bad++; $display("FAIL dl_wait_drop: wait=%b we=%b want 0 0", dl_wait, ddr_we); end
    dl_en = 1'b0;
    @(negedge clk_sys);
    set_addr(15'h0124);
    pulse_rd();
    total++; if (ddr_rd !== 1'b1 || ready !== 1'b0) begin bad++; $display("FAIL dl_invalidate: rd=%b ready=%b want 1 0", ddr_rd, ready); end
    ddr_reply(64'h887766554433A511, 2);
    total++; if (dout !== 8'h55) begin bad++; $display("FAIL dl_reread: got %h want 55", dout); end
  endtask

  task automatic test_wr_during_miss();
    set_addr(15'h0140);
    ddr_busy = 1'b1;
    pulse_rd();
    total++; if (ready !== 1'b0 || ddr_rd !== 1'b1) begin bad++; $display("FAIL wm_miss: ready=%b rd=%b want 0 1", ready, ddr_rd); end
    dl_addr = 19'h00007;
    dl_data = 8'h3C;
    dl_wr = 1'b1;
    @(negedge clk_sys);
    dl_wr = 1'b0;
    total++; if (dl_wait !== 1'b1 || ddr_we !== 1'b0 || ddr_rd !== 1'b1) begin bad++; $display("FAIL wm_wait_rise: wait=%b we=%b rd=%b want 1 0 1", dl_wait, ddr_we, ddr_rd); end
    ddr_busy = 1'b0;
    @(negedge clk_sys);
    total++; if (ddr_rd !== 1'b0 || ddr_we !== 1'b0) begin bad++; $display("FAIL wm_rd_wait: rd=%b we=%b want 0 0", ddr_rd, ddr_we); end
    ddr_dout = 64'h00000000000000C7;
    ddr_dout_ready = 1'b1;
    @(negedge clk_sys);
    ddr_dout_ready = 1'b0;
    total++; if (ready !== 1'b1 || dout !== 8'hC7 || ddr_we !== 1'b0) begin bad++; $display("FAIL wm_fill: ready=%b dout=%h we=%b want 1 c7 0", ready, dout, ddr_we); end
    @(negedge clk_sys);
    total++; if (ddr_we !== 1'b1 || ddr_be !== 8'h80 || ddr_addr !== BASE) begin bad++; $display("FAIL wm_write: we=%b be=%h addr=%h want 1 80 %h", ddr_we, ddr_be, ddr_addr, BASE); end
    @(negedge clk_sys);
    total++; if (dl_wait !== 1'b0 || ddr_we !== 1'b0) begin bad++; $display("FAIL wm_done: wait=%b we=%b want 0 0", dl_wait, ddr_we); end
  endtask

  task automatic test_conflict();
    logic [14:0] a;
    logic [7:0] b;
    for (int i = 0; i < 4; i++) begin
      a = (i % 2 == 0) ? 15'h0100 : 15'h0200;
      b = 8'hD0 + 8'(i);
      set_addr(a);
      pulse_rd();
      total++; if (ddr_rd !== 1'b1 || ddr_addr !== BASE + 29'(a >> 3)) begin bad++; $display("FAIL conflict_miss_%0d: rd=%b addr=%h want 1 %h", i, ddr_rd, ddr_addr, BASE + 29'(a >> 3)); end
      ddr_reply({56'h0, b}, 2);
      total++; if (dout !== b) begin bad++; $display("FAIL conflict_dout_%0d: got %h want %h", i, dout, b); end
    end
    set_addr(15'h0201);
    pulse_rd();
    total++; if (ddr_rd !== 1'b0 || ready !== 1'b1 || dout !== 8'h00) begin bad++; $display("FAIL conflict_final_hit: rd=%b ready=%b dout=%h want 0 1 00", ddr_rd, ready, dout); end
  endtask

  task automatic test_reset_mid();
    set_addr(15'h0300);
    pulse_rd();
    @(negedge clk_sys);
    total++; if (ready !== 1'b0 || ddr_rd !== 1'b0) begin bad++; $display("FAIL rm_in_wait: ready=%b rd=%b want 0 0", ready, ddr_rd); end
    reset_n = 1'b0;
    #1;
    total++; if (ready !== 1'b1 || dout !== 8'hFF) begin bad++; $display("FAIL rm_async: ready=%b dout=%h want 1 ff", ready, dout); end
    @(negedge clk_sys);
    reset_n = 1'b1;
    @(negedge clk_sys);
    ddr_dout = 64'h00000000000000EE;
    ddr_dout_ready = 1'b1;
    @(negedge clk_sys);
    ddr_dout_ready = 1'b0;
    total++; if (ready !== 1'b1 || dout !== 8'hFF || ddr_rd !== 1'b0) begin bad++; $display("FAIL rm_late_data: ready=%b dout=%h rd=%b want 1 ff 0", ready, dout, ddr_rd); end
    pulse_rd();
    total++; if (ddr_rd !== 1'b1 || ddr_addr !== BASE + 29'h60) begin bad++; $display("FAIL rm_refetch: rd=%b addr=%h want 1 %h", ddr_rd, ddr_addr, BASE + 29'h60); end
    ddr_reply(64'h0000000000000077, 2);
    total++; if (dout !== 8'h77) begin bad++; $display("FAIL rm_refetch_dout: got %h want 77", dout); end
  endtask

  initial begin
    test_reset();
    test_page();
    test_cold_read();
    test_hit();
    test_download();
    test_wr_during_miss();
    test_conflict();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
